// File: rtl/mem_arbiter.sv
// Two-requester (fetch, load/store) arbiter onto a single memory port, one transaction in flight.
// Define MEM_ARBITER_RR_EN for round-robin arbitration; otherwise load/store has fixed priority.
module mem_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   // instruction fetch port
   input  logic                if_req_valid,
   input  logic [ADDR_W-1:0]   if_req_addr,
   output logic                if_req_ready,
   output logic                if_rsp_valid,
   output logic [DATA_W-1:0]   if_rsp_rdata,
   // load/store port
   input  logic                ls_req_valid,
   input  logic [ADDR_W-1:0]   ls_req_addr,
   input  logic                ls_req_we,
   input  logic [DATA_W-1:0]   ls_req_wdata,
   input  logic [DATA_W/8-1:0] ls_req_be,
   output logic                ls_req_ready,
   output logic                ls_rsp_valid,
   output logic [DATA_W-1:0]   ls_rsp_rdata,
   // downstream memory port
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_req_addr,
   output logic                mem_req_we,
   output logic [DATA_W-1:0]   mem_req_wdata,
   output logic [DATA_W/8-1:0] mem_req_be,
   input  logic                mem_rsp_valid,
   input  logic [DATA_W-1:0]   mem_rsp_rdata
);

   localparam int unsigned BE_W = DATA_W / 8;

   typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

   state_e            state_q, state_d;
   logic              grant_if, grant_ls, accept;
   logic              owner_ls_q;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [DATA_W-1:0] wdata_q;
   logic [BE_W-1:0]   be_q;

   assign accept = (state_q == StIdle) && (if_req_valid || ls_req_valid);

`ifdef MEM_ARBITER_RR_EN
   // 1 = load/store won the most recent grant; a tie goes to the other requester
   logic last_ls_q;

   always_comb begin
      grant_ls = ls_req_valid && (!if_req_valid || !last_ls_q);
      grant_if = if_req_valid && !grant_ls;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_ls_q <= 1'b0;
      end else if (accept) begin
         last_ls_q <= grant_ls;
      end
   end
`else
   assign grant_ls = ls_req_valid;
   assign grant_if = if_req_valid && !ls_req_valid;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept)        state_d = StReq;
         StReq:   if (mem_req_ready) state_d = StResp;
         StResp:  if (mem_rsp_valid) state_d = StIdle;
         default:                    state_d = StIdle;
      endcase
   end

   always_comb begin
      if_req_ready  = 1'b0;
      ls_req_ready  = 1'b0;
      mem_req_valid = 1'b0;
      if_rsp_valid  = 1'b0;
      ls_rsp_valid  = 1'b0;
      unique case (state_q)
         // gate with rst_n so nothing is offered while reset is held
         StIdle: begin
            if_req_ready = rst_n && grant_if;
            ls_req_ready = rst_n && grant_ls;
         end
         StReq:  mem_req_valid = 1'b1;
         StResp: begin
            if_rsp_valid = mem_rsp_valid && !owner_ls_q;
            ls_rsp_valid = mem_rsp_valid && owner_ls_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_ls_q <= 1'b0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         be_q       <= '0;
      end else if (accept) begin
         owner_ls_q <= grant_ls;
         addr_q     <= grant_ls ? ls_req_addr : if_req_addr;
         we_q       <= grant_ls && ls_req_we;
         wdata_q    <= grant_ls ? ls_req_wdata : '0;
         be_q       <= grant_ls ? ls_req_be : '1;
      end
   end

   assign mem_req_addr  = addr_q;
   assign mem_req_we    = we_q;
   assign mem_req_wdata = wdata_q;
   assign mem_req_be    = be_q;
   assign if_rsp_rdata  = mem_rsp_rdata;
   assign ls_rsp_rdata  = mem_rsp_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a small memory model (rdata = addr + 3).
// Arbitration expectations follow MEM_ARBITER_RR_EN when it is defined.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req_valid, if_req_ready, if_rsp_valid;
   logic [31:0] if_req_addr, if_rsp_rdata;
   logic        ls_req_valid, ls_req_we, ls_req_ready, ls_rsp_valid;
   logic [31:0] ls_req_addr, ls_req_wdata, ls_rsp_rdata;
   logic [3:0]  ls_req_be;
   logic        mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid;
   logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_rdata;
   logic [3:0]  mem_req_be;

   typedef struct {
      bit          is_ls;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } txn_t;

   txn_t sb_q[$];
   txn_t mon_e;
   int   n_checks = 0;
   int   n_pass   = 0;
   bit   last_ls  = 1'b0;
   int   stall_left = 0;
   bit   drop_rsp = 1'b0;
   bit   stray    = 1'b0;
   bit          mdl_hs;
   logic [31:0] mdl_addr;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .if_req_valid  (if_req_valid),
      .if_req_addr   (if_req_addr),
      .if_req_ready  (if_req_ready),
      .if_rsp_valid  (if_rsp_valid),
      .if_rsp_rdata  (if_rsp_rdata),
      .ls_req_valid  (ls_req_valid),
      .ls_req_addr   (ls_req_addr),
      .ls_req_we     (ls_req_we),
      .ls_req_wdata  (ls_req_wdata),
      .ls_req_be     (ls_req_be),
      .ls_req_ready  (ls_req_ready),
      .ls_rsp_valid  (ls_rsp_valid),
      .ls_rsp_rdata  (ls_rsp_rdata),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_addr  (mem_req_addr),
      .mem_req_we    (mem_req_we),
      .mem_req_wdata (mem_req_wdata),
      .mem_req_be    (mem_req_be),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_rdata (mem_rsp_rdata)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else n_pass++;
   endtask

   // Memory model: response one cycle after the handshake, optional ready stall
   initial begin
      mem_req_ready = 1'b1;
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = '0;
      forever begin
         @(negedge clk);
         mdl_hs   = rst_n && mem_req_valid && mem_req_ready;
         mdl_addr = mem_req_addr;
         @(posedge clk);
         #2;
         mem_rsp_valid = 1'b0;
         if (stray) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = 32'hDEADBEEF;
            stray         = 1'b0;
         end else if (mdl_hs && !drop_rsp) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = mdl_addr + 32'h3;
         end
         if (mem_req_valid && stall_left > 0) begin
            mem_req_ready = 1'b0;
            stall_left--;
         end else begin
            mem_req_ready = 1'b1;
         end
      end
   end

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_req_valid) begin
            if (sb_q.size() == 0) begin
               check_eq("mem_req_unexpected", mem_req_valid, 0);
            end else begin
               check_eq("mem_req_addr", mem_req_addr, sb_q[0].addr);
               check_eq("mem_req_we", mem_req_we, sb_q[0].we);
               check_eq("mem_req_be", mem_req_be, sb_q[0].be);
               if (sb_q[0].we) check_eq("mem_req_wdata", mem_req_wdata, sb_q[0].wdata);
            end
         end
         if (if_rsp_valid || ls_rsp_valid) begin
            if (sb_q.size() == 0) begin
               check_eq("rsp_unexpected", {if_rsp_valid, ls_rsp_valid}, 0);
            end else begin
               mon_e = sb_q.pop_front();
               check_eq("rsp_if_valid", if_rsp_valid, !mon_e.is_ls);
               check_eq("rsp_ls_valid", ls_rsp_valid, mon_e.is_ls);
               if (!mon_e.we)
                  check_eq("rsp_rdata", mon_e.is_ls ? ls_rsp_rdata : if_rsp_rdata,
                           mon_e.addr + 32'h3);
            end
         end
      end
   end

   task automatic issue(input bit is_ls, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
      bit   ok = 1'b0;
      txn_t t;
      if (is_ls) begin
         ls_req_valid = 1'b1;
         ls_req_addr  = addr;
         ls_req_we    = we;
         ls_req_wdata = wdata;
         ls_req_be    = be;
      end else begin
         if_req_valid = 1'b1;
         if_req_addr  = addr;
      end
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (is_ls ? ls_req_ready : if_req_ready) begin
            ok = 1'b1;
            check_eq("loser_ready", is_ls ? if_req_ready : ls_req_ready, 0);
            t.is_ls = is_ls;
            t.we    = is_ls && we;
            t.addr  = addr;
            t.wdata = wdata;
            t.be    = is_ls ? be : 4'hF;
            sb_q.push_back(t);
            last_ls = is_ls;
         end
         @(posedge clk);
         #1;
      end
      check_eq("accept", ok, 1);
      if_req_valid = 1'b0;
      ls_req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int c = 0;
      while (sb_q.size() != 0 && c < 100) begin
         @(negedge clk);
         c++;
      end
      check_eq("drain", sb_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic both_loop(input int n);
      int          grants = 0;
      logic [31:0] ia = 32'h100;
      logic [31:0] la = 32'h200;
      bit          exp_ls;
      txn_t        t;
      if_req_valid = 1'b1;
      ls_req_valid = 1'b1;
      ls_req_we    = 1'b0;
      ls_req_be    = 4'hF;
      if_req_addr  = ia;
      ls_req_addr  = la;
      for (int c = 0; c < 200 && grants < n; c++) begin
         @(negedge clk);
         if (if_req_ready || ls_req_ready) begin
`ifdef MEM_ARBITER_RR_EN
            exp_ls = !last_ls;
`else
            exp_ls = 1'b1;
`endif
            check_eq("arb_ls_ready", ls_req_ready, exp_ls);
            check_eq("arb_if_ready", if_req_ready, !exp_ls);
            t.is_ls = exp_ls;
            t.we    = 1'b0;
            t.addr  = exp_ls ? la : ia;
            t.wdata = '0;
            t.be    = 4'hF;
            sb_q.push_back(t);
            last_ls = exp_ls;
            grants++;
            if (exp_ls) la = la + 32'h4;
            else        ia = ia + 32'h4;
         end
         @(posedge clk);
         #1;
         if_req_addr = ia;
         ls_req_addr = la;
      end
      check_eq("arb_grants", grants, n);
      if_req_valid = 1'b0;
      ls_req_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst_n        = 1'b0;
      if_req_valid = 1'b1;
      if_req_addr  = 32'h0;
      ls_req_valid = 1'b1;
      ls_req_addr  = 32'h0;
      ls_req_we    = 1'b0;
      ls_req_wdata = 32'h0;
      ls_req_be    = 4'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_if_ready", if_req_ready, 0);
      check_eq("rst_ls_ready", ls_req_ready, 0);
      check_eq("rst_mem_valid", mem_req_valid, 0);
      check_eq("rst_mem_fields", {mem_req_addr, mem_req_we, mem_req_wdata, mem_req_be}, 0);
      if_req_valid = 1'b0;
      ls_req_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // fetch only, memory always ready
      issue(1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
      @(negedge clk);
      check_eq("fetch_mem_valid", mem_req_valid, 1);
      check_eq("fetch_mem_we", mem_req_we, 0);
      check_eq("fetch_mem_be", mem_req_be, 4'hF);
      @(negedge clk);
      check_eq("fetch_rsp_valid", if_rsp_valid, 1);
      check_eq("fetch_rsp_rdata", if_rsp_rdata, 32'h13);
      check_eq("fetch_ls_quiet", ls_rsp_valid, 0);
      wait_idle();

      // store with memory ready held low for three cycles
      stall_left = 3;
      issue(1'b1, 1'b1, 32'h10, 32'hABCDEF11, 4'hF);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("st_mem_valid", mem_req_valid, 1);
         check_eq("st_mem_ready", mem_req_ready, (i == 3) ? 1 : 0);
         check_eq("st_mem_we", mem_req_we, 1);
         check_eq("st_mem_wdata", mem_req_wdata, 32'hABCDEF11);
         check_eq("st_rsp_early", ls_rsp_valid, 0);
      end
      @(negedge clk);
      check_eq("st_rsp_valid", ls_rsp_valid, 1);
      check_eq("st_if_quiet", if_rsp_valid, 0);
      wait_idle();

      // stray response while idle
      stray = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_eq("stray_if", if_rsp_valid, 0);
      check_eq("stray_ls", ls_rsp_valid, 0);
      @(posedge clk);
      #1;

      both_loop(6);
      wait_idle();

      // reset while the memory response is outstanding
      drop_rsp = 1'b1;
      issue(1'b0, 1'b0, 32'h40, 32'h0, 4'h0);
      @(posedge clk);
      #1;
      rst_n        = 1'b0;
      if_req_valid = 1'b1;
      ls_req_valid = 1'b1;
      #1;
      check_eq("mid_rst_ready", {if_req_ready, ls_req_ready}, 0);
      check_eq("mid_rst_valid", {mem_req_valid, if_rsp_valid, ls_rsp_valid}, 0);
      check_eq("mid_rst_fields", {mem_req_addr, mem_req_be}, 0);
      sb_q.delete();
      last_ls = 1'b0;
      @(posedge clk);
      #1;
      if_req_valid = 1'b0;
      ls_req_valid = 1'b0;
      rst_n        = 1'b1;
      stray        = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_eq("late_rsp_if", if_rsp_valid, 0);
      check_eq("late_rsp_ls", ls_rsp_valid, 0);
      @(posedge clk);
      #1;
      drop_rsp = 1'b0;
      issue(1'b1, 1'b0, 32'h80, 32'h0, 4'h3);
      wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
- REQ-001: Parameter ADDR_W, default 32, width of every address bus.
- REQ-002: Parameter DATA_W, default 32, width of every data bus; byte-enable width is DATA_W/8.
- REQ-003: The block SHALL use one clock and an asynchronous, active-low reset.
- REQ-004: clk  in  1  single clock, all state updates on rising edge.
- REQ-005: rst_n  in  1  asynchronous active-low reset.
- REQ-006: if_req_valid  in  1  instruction-fetch read request.
- REQ-007: if_req_addr  in  ADDR_W  fetch address.
- REQ-008: if_req_ready  out  1  fetch request accepted this cycle.
- REQ-009: if_rsp_valid  out  1  fetch read data valid, one-cycle pulse.
- REQ-010: if_rsp_rdata  out  DATA_W  fetch read data.
- REQ-011: ls_req_valid  in  1  load/store request.
- REQ-012: ls_req_addr  in  ADDR_W  load/store address.
- REQ-013: ls_req_we  in  1  1 = store, 0 = load.
- REQ-014: ls_req_wdata  in  DATA_W  store data.
- REQ-015: ls_req_be  in  DATA_W/8  store byte enables.
- REQ-016: ls_req_ready  out  1  load/store request accepted this cycle.
- REQ-017: ls_rsp_valid  out  1  load data or store acknowledge, one-cycle pulse.
- REQ-018: ls_rsp_rdata  out  DATA_W  load data; don't-care for stores.
- REQ-019: mem_req_valid / mem_req_ready  out / in  1  downstream request handshake.
- REQ-020: mem_req_addr, mem_req_we, mem_req_wdata, mem_req_be  out  ADDR_W, 1, DATA_W, DATA_W/8  downstream request fields.
- REQ-021: mem_rsp_valid / mem_rsp_rdata  in  1 / DATA_W  downstream response.

Function
- REQ-022: FSM states IDLE, REQ, RESP; exactly one transaction outstanding at any time.
- REQ-023: IDLE: if either *_req_valid is high, arbitrate, assert the winner's *_req_ready combinationally the same cycle, register the winner's fields plus owner ID, and go to REQ.
- REQ-024: *_req_ready SHALL be 0 outside IDLE and 0 for the losing requester.
- REQ-025: REQ: mem_req_valid = 1 with registered fields held stable; on mem_req_valid & mem_req_ready go to RESP.
- REQ-026: RESP: on mem_rsp_valid, pulse the owner's *_rsp_valid for that cycle with *_rsp_rdata = mem_rsp_rdata (combinational pass-through), and go to IDLE.
- REQ-027: Fetch requests SHALL always drive mem_req_we = 0 and mem_req_be = all ones.
- REQ-028: mem_rsp_valid outside RESP SHALL be ignored; no *_rsp_valid asserted.
- REQ-029: The non-owner *_rsp_valid SHALL stay 0 throughout a transaction.
- REQ-030: Minimum latency is 2 cycles from accept to response: accept in IDLE, mem_req_ready in REQ, mem_rsp_valid in the first RESP cycle.
- REQ-031: Back-to-back throughput is at most one transaction per 3 cycles.
- REQ-032: Requester valid deasserting after acceptance SHALL NOT affect the transaction in flight.

Reset
- REQ-033: While rst_n = 0, state = IDLE, all *_valid and *_ready outputs = 0, registered mem_req_* fields = 0, and the round-robin pointer = IF.
- REQ-034: Reset mid-transaction SHALL abandon it immediately; no response is issued for it afterwards.

Configuration
- REQ-035: Macro MEM_ARBITER_RR_EN.
- REQ-036: With MEM_ARBITER_RR_EN defined, simultaneous requests grant the requester not granted last, and a one-bit last-grant register updates on every grant.
- REQ-037: Without MEM_ARBITER_RR_EN, load/store always wins over fetch and no pointer register exists.

Verification
- REQ-038: Fetch only, addr 0x00000010, memory ready = 1, rdata 0x00000013 one cycle later -> if_req_ready in cycle 0, if_rsp_valid with 0x00000013 in cycle 2, ls_rsp_valid stays 0.
- REQ-039: Store addr 0x10, wdata 0xABCDEF11, be 0xF, mem_req_ready held low 3 cycles -> fields stable on mem_req_*, mem_req_we = 1, ls_rsp_valid only after mem_rsp_valid.
- REQ-040: Both request every cycle, RR disabled -> ls wins every arbitration and fetch starves; RR enabled -> grants alternate LS, IF, LS, IF.
- REQ-041: Stray mem_rsp_valid with 0xDEADBEEF while in IDLE -> no *_rsp_valid pulse.
- REQ-042: rst_n low during RESP, then a late mem_rsp_valid -> no response issued; first new request handled normally.
